// File: rtl/parking_pkg.sv
// Shared types, glyphs and helpers for the parking entrance controller.
package parking_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT    = 3'd1,
        S_DENIED  = 3'd2,
        S_GRANTED = 3'd3,
        S_STOP    = 3'd4,
        S_LOCKOUT = 3'd5,
        S_FULL    = 3'd6
    } state_t;

    // Active-low 7-seg glyphs, bit6=g .. bit0=a
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_N     = 7'h2B;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_P     = 7'h0C;
    localparam logic [6:0] SEG_L     = 7'h47;
    localparam logic [6:0] SEG_O     = 7'h40;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_U     = 7'h63;

    // {tens, units} of a 0..99 value using constant compares instead of a divider
    function automatic logic [7:0] bcd_split(input logic [6:0] val);
        logic [3:0] tens;
        tens = 4'd0;
        for (int i = 1; i <= 9; i++)
            if (val >= 7'(10 * i)) tens = 4'(i);
        return {tens, 4'(val - 7'(tens) * 7'd10)};
    endfunction

endpackage

// File: rtl/parking_if.sv
// Lane sensors/keypad in, front-panel lamps and digits out.
interface parking_if #(
    parameter int PASS_W = 4,
    parameter int CNT_W  = 7
);
    logic              sensor_entrance;
    logic              sensor_exit;
    logic              sensor_depart;
    logic              pass_valid;
    logic [PASS_W-1:0] pass_code;
    logic              GREEN_LED;
    logic              RED_LED;
    logic              gate_open;
    logic              lot_full;
    logic [CNT_W-1:0]  occupancy;
    logic [6:0]        HEX_1;
    logic [6:0]        HEX_2;

    modport master (
        output sensor_entrance, sensor_exit, sensor_depart, pass_valid, pass_code,
        input  GREEN_LED, RED_LED, gate_open, lot_full, occupancy, HEX_1, HEX_2
    );

    modport slave (
        input  sensor_entrance, sensor_exit, sensor_depart, pass_valid, pass_code,
        output GREEN_LED, RED_LED, gate_open, lot_full, occupancy, HEX_1, HEX_2
    );
endinterface

// File: rtl/seg7_dec.sv
// BCD digit to active-low 7-segment pattern; codes 10..15 blank the digit.
module seg7_dec (
    input  logic [3:0] bcd,
    output logic [6:0] seg
);
    always_comb begin
        case (bcd)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = 7'h7F;
        endcase
    end
endmodule

// File: rtl/parking_gate_ctrl.sv
// Single-lane parking entrance controller: code entry, lockout, tailgate stop,
// occupancy tracking and free-space display.
module parking_gate_ctrl
    import parking_pkg::*;
#(
    parameter int                CAPACITY     = 20,
    parameter int                CNT_W        = 7,
    parameter int                PASS_W       = 4,
    parameter logic [PASS_W-1:0] PASSWORD     = 4'b0110,
    parameter int                MAX_TRIES    = 3,
    parameter int                PASS_TIMEOUT = 64,
    parameter int                GATE_TIMEOUT = 128,
    parameter int                LOCKOUT_CYC  = 256,
    parameter int                BLINK_DIV    = 8
) (
    input logic       clk,
    input logic       reset_n,
    parking_if.slave  bus
);
    localparam int T_MAX = (LOCKOUT_CYC > GATE_TIMEOUT)
        ? ((LOCKOUT_CYC > PASS_TIMEOUT) ? LOCKOUT_CYC : PASS_TIMEOUT)
        : ((GATE_TIMEOUT > PASS_TIMEOUT) ? GATE_TIMEOUT : PASS_TIMEOUT);
    localparam int TMR_W = (T_MAX > 2) ? $clog2(T_MAX) : 1;
    localparam int DIV_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam int TRY_W = $clog2(MAX_TRIES + 1);

    state_t           state, state_nxt;
    logic [TMR_W-1:0] timer;
    logic [TRY_W-1:0] tries, tries_nxt;
    logic [CNT_W-1:0] occ, occ_nxt, free_cnt;
    logic [DIV_W-1:0] div_cnt;
    logic             blink, depart_prev, depart_edge, full, code_ok, car_in;
    logic [7:0]       digits;
    logic [3:0]       tens_bcd;
    logic [6:0]       seg_tens, seg_units, hex1, hex2;
    logic             green, red, gate_q, full_q;

    assign full        = occ >= CNT_W'(CAPACITY);
    assign code_ok     = bus.pass_valid && (bus.pass_code == PASSWORD);
    assign depart_edge = bus.sensor_depart && !depart_prev;

    always_comb begin
        state_nxt = state;
        tries_nxt = tries;
        car_in    = 1'b0;
        case (state)
            S_IDLE:
                if (bus.sensor_entrance) state_nxt = full ? S_FULL : S_WAIT;
            S_WAIT, S_DENIED:
                // A code presented this cycle wins over timeout / car leaving
                if (bus.pass_valid) begin
                    if (code_ok) begin
                        state_nxt = S_GRANTED;
                        tries_nxt = '0;
                    end else begin
                        tries_nxt = tries + 1'b1;
                        state_nxt = (tries_nxt == TRY_W'(MAX_TRIES)) ? S_LOCKOUT : S_DENIED;
                    end
                end else if (!bus.sensor_entrance || timer == TMR_W'(PASS_TIMEOUT - 1)) begin
                    state_nxt = S_IDLE;
                    tries_nxt = '0;
                end
            S_GRANTED:
                if (bus.sensor_exit) begin
                    if (bus.sensor_entrance) begin
                        state_nxt = S_STOP;
                    end else begin
                        state_nxt = S_IDLE;
                        car_in    = 1'b1;
                    end
                end else if (timer == TMR_W'(GATE_TIMEOUT - 1)) begin
                    state_nxt = S_IDLE;
                end
            S_STOP:
                if (code_ok) state_nxt = S_GRANTED;
            S_LOCKOUT:
                if (timer == TMR_W'(LOCKOUT_CYC - 1)) begin
                    state_nxt = S_IDLE;
                    tries_nxt = '0;
                end
            S_FULL:
                if (!bus.sensor_entrance || !full) state_nxt = S_IDLE;
            default:
                state_nxt = S_IDLE;
        endcase
    end

    // Entry and departure in the same cycle cancel out
    always_comb begin
        occ_nxt = occ;
        if (car_in && !depart_edge && !full)
            occ_nxt = occ + 1'b1;
        else if (depart_edge && !car_in && occ != '0)
            occ_nxt = occ - 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            timer       <= '0;
            tries       <= '0;
            occ         <= '0;
            depart_prev <= 1'b0;
            div_cnt     <= '0;
            blink       <= 1'b0;
        end else begin
            state       <= state_nxt;
            timer       <= (state_nxt != state) ? '0 : timer + 1'b1;
            tries       <= tries_nxt;
            occ         <= occ_nxt;
            depart_prev <= bus.sensor_depart;
            if (div_cnt == DIV_W'(BLINK_DIV - 1)) begin
                div_cnt <= '0;
                blink   <= ~blink;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    assign free_cnt = CNT_W'(CAPACITY) - occ;
    assign digits   = bcd_split(7'(free_cnt));
    assign tens_bcd = (digits[7:4] == 4'd0) ? 4'hF : digits[7:4];

    seg7_dec u_tens  (.bcd(tens_bcd),    .seg(seg_tens));
    seg7_dec u_units (.bcd(digits[3:0]), .seg(seg_units));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            green  <= 1'b0;
            red    <= 1'b0;
            gate_q <= 1'b0;
            full_q <= 1'b0;
            hex1   <= SEG_BLANK;
            hex2   <= SEG_BLANK;
        end else begin
            green  <= 1'b0;
            red    <= 1'b1;
            gate_q <= (state == S_GRANTED);
            full_q <= (occ_nxt >= CNT_W'(CAPACITY));
            case (state)
                S_IDLE: begin
                    red  <= 1'b0;
                    hex1 <= seg_tens;
                    hex2 <= seg_units;
                end
                S_WAIT:    {hex1, hex2} <= {SEG_E, SEG_N};
                S_DENIED: begin
                    red          <= blink;
                    {hex1, hex2} <= {SEG_E, SEG_E};
                end
                S_GRANTED: begin
                    green        <= blink;
                    red          <= 1'b0;
                    {hex1, hex2} <= {SEG_6, SEG_0};
                end
                S_STOP: begin
                    red          <= blink;
                    {hex1, hex2} <= {SEG_5, SEG_P};
                end
                S_LOCKOUT: {hex1, hex2} <= {SEG_L, SEG_O};
                S_FULL:    {hex1, hex2} <= {SEG_F, SEG_U};
                default: begin
                    red          <= 1'b0;
                    {hex1, hex2} <= {SEG_BLANK, SEG_BLANK};
                end
            endcase
        end
    end

    assign bus.GREEN_LED = green;
    assign bus.RED_LED   = red;
    assign bus.gate_open = gate_q;
    assign bus.lot_full  = full_q;
    assign bus.occupancy = occ;
    assign bus.HEX_1     = hex1;
    assign bus.HEX_2     = hex2;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Scoreboard bench: a behavioural lot model queues expected panel outputs each
// clock; a monitor on the falling edge compares them with the controller.
module tb_parking_gate_ctrl;

    localparam int         CAP          = 20;
    localparam logic [3:0] PW           = 4'b0110;
    localparam int         MAX_TRIES    = 3;
    localparam int         PASS_TIMEOUT = 64;
    localparam int         GATE_TIMEOUT = 128;
    localparam int         LOCKOUT_CYC  = 256;
    localparam int         BLINK_DIV    = 8;

    localparam logic [6:0] DIG [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                        7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    typedef struct packed {
        logic       g;
        logic       r;
        logic       gate;
        logic       full;
        logic [6:0] occ;
        logic [6:0] h1;
        logic [6:0] h2;
    } exp_t;

    typedef enum {M_IDLE, M_WAIT, M_DENIED, M_GRANTED, M_STOP, M_LOCK, M_FULL} mst_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exp_q[$];

    parking_if #(.PASS_W(4), .CNT_W(7)) bus ();

    parking_gate_ctrl #(
        .CAPACITY(CAP), .CNT_W(7), .PASS_W(4), .PASSWORD(PW), .MAX_TRIES(MAX_TRIES),
        .PASS_TIMEOUT(PASS_TIMEOUT), .GATE_TIMEOUT(GATE_TIMEOUT),
        .LOCKOUT_CYC(LOCKOUT_CYC), .BLINK_DIV(BLINK_DIV)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference model: lot state kept as plain integers
    mst_t m_st    = M_IDLE;
    int   m_occ   = 0;
    int   m_tries = 0;
    int   m_age   = 0;
    int   m_cyc   = 0;
    bit   m_prev_dep = 1'b0;

    always @(posedge clk) begin
        exp_t e;
        mst_t nst;
        int   free_b;
        bit   blink, dep, car_in, full;
        if (!reset_n) begin
            m_st = M_IDLE; m_occ = 0; m_tries = 0; m_age = 0; m_cyc = 0; m_prev_dep = 1'b0;
            e = '{g: 1'b0, r: 1'b0, gate: 1'b0, full: 1'b0, occ: 7'd0, h1: 7'h7F, h2: 7'h7F};
        end else begin
            blink = ((m_cyc / BLINK_DIV) % 2) == 1;
            m_cyc++;
            free_b = CAP - m_occ;
            e.g    = (m_st == M_GRANTED) && blink;
            e.r    = (m_st == M_WAIT || m_st == M_LOCK || m_st == M_FULL) ||
                     ((m_st == M_DENIED || m_st == M_STOP) && blink);
            e.gate = (m_st == M_GRANTED);
            case (m_st)
                M_IDLE: begin
                    e.h1 = (free_b >= 10) ? DIG[free_b / 10] : 7'h7F;
                    e.h2 = DIG[free_b % 10];
                end
                M_WAIT:    {e.h1, e.h2} = {7'h06, 7'h2B};
                M_DENIED:  {e.h1, e.h2} = {7'h06, 7'h06};
                M_GRANTED: {e.h1, e.h2} = {7'h02, 7'h40};
                M_STOP:    {e.h1, e.h2} = {7'h12, 7'h0C};
                M_LOCK:    {e.h1, e.h2} = {7'h47, 7'h40};
                default:   {e.h1, e.h2} = {7'h0E, 7'h63};
            endcase

            full = m_occ >= CAP;
            dep  = bus.sensor_depart && !m_prev_dep;
            m_prev_dep = bus.sensor_depart;
            nst    = m_st;
            car_in = 1'b0;
            case (m_st)
                M_IDLE: if (bus.sensor_entrance) nst = full ? M_FULL : M_WAIT;
                M_WAIT, M_DENIED:
                    if (bus.pass_valid) begin
                        if (bus.pass_code == PW) begin
                            nst = M_GRANTED; m_tries = 0;
                        end else begin
                            m_tries++;
                            nst = (m_tries >= MAX_TRIES) ? M_LOCK : M_DENIED;
                        end
                    end else if (!bus.sensor_entrance || m_age == PASS_TIMEOUT - 1) begin
                        nst = M_IDLE; m_tries = 0;
                    end
                M_GRANTED:
                    if (bus.sensor_exit && bus.sensor_entrance) nst = M_STOP;
                    else if (bus.sensor_exit) begin nst = M_IDLE; car_in = 1'b1; end
                    else if (m_age == GATE_TIMEOUT - 1) nst = M_IDLE;
                M_STOP: if (bus.pass_valid && bus.pass_code == PW) nst = M_GRANTED;
                M_LOCK: if (m_age == LOCKOUT_CYC - 1) begin nst = M_IDLE; m_tries = 0; end
                default: if (!bus.sensor_entrance || !full) nst = M_IDLE;
            endcase
            if (car_in && !dep)       m_occ = (m_occ < CAP) ? m_occ + 1 : m_occ;
            else if (dep && !car_in)  m_occ = (m_occ > 0) ? m_occ - 1 : 0;
            e.full = m_occ >= CAP;
            e.occ  = 7'(m_occ);
            m_age  = (nst == m_st) ? m_age + 1 : 0;
            m_st   = nst;
        end
        exp_q.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e, got;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = '{g: bus.GREEN_LED, r: bus.RED_LED, gate: bus.gate_open, full: bus.lot_full,
                    occ: bus.occupancy, h1: bus.HEX_1, h2: bus.HEX_2};
            n_cmp++;
            if (got !== e) begin
                n_bad++;
                $display("FAIL outputs t=%0t got g=%b r=%b gate=%b full=%b occ=%0d hex=%h/%h want g=%b r=%b gate=%b full=%b occ=%0d hex=%h/%h",
                         $time, got.g, got.r, got.gate, got.full, got.occ, got.h1, got.h2,
                         e.g, e.r, e.gate, e.full, e.occ, e.h1, e.h2);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic enter_code(input logic [3:0] c);
        bus.pass_code  = c;
        bus.pass_valid = 1'b1;
        cyc();
        bus.pass_valid = 1'b0;
        bus.pass_code  = 4'($urandom);
    endtask

    task automatic admit_car(input bit with_depart);
        bus.sensor_entrance = 1'b1;
        cyc(2 + $urandom_range(0, 3));
        enter_code(PW);
        cyc(1 + $urandom_range(0, 2));
        bus.sensor_entrance = 1'b0;
        bus.sensor_exit     = 1'b1;
        bus.sensor_depart   = with_depart;
        cyc();
        bus.sensor_exit     = 1'b0;
        bus.sensor_depart   = 1'b0;
        cyc(2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.sensor_entrance = 1'b0;
        bus.sensor_exit     = 1'b0;
        bus.sensor_depart   = 1'b0;
        bus.pass_valid      = 1'b0;
        bus.pass_code       = 4'h0;
        cyc(3);
        #2 reset_n = 1'b1;
        cyc(4);

        // Single admission: 20 -> 19 free
        admit_car(1'b0);
        cyc(3);

        // Three wrong codes -> lockout; a correct code inside lockout is ignored
        bus.sensor_entrance = 1'b1;
        cyc(2);
        for (int i = 0; i < 3; i++) begin
            enter_code(4'b0000);
            cyc(2);
        end
        cyc(10);
        enter_code(PW);
        cyc(250);
        bus.sensor_entrance = 1'b0;
        cyc(4);

        // Tailgate -> STOP, wrong code holds, correct code re-grants
        bus.sensor_entrance = 1'b1;
        cyc(2);
        enter_code(PW);
        cyc(2);
        bus.sensor_exit = 1'b1;
        cyc();
        bus.sensor_exit = 1'b0;
        cyc(20);
        enter_code(4'b0000);
        cyc(5);
        enter_code(PW);
        cyc(2);
        bus.sensor_entrance = 1'b0;
        bus.sensor_exit     = 1'b1;
        cyc();
        bus.sensor_exit     = 1'b0;
        cyc(3);

        // Gate timeout in GRANTED without a pass
        bus.sensor_entrance = 1'b1;
        cyc(2);
        enter_code(PW);
        cyc(GATE_TIMEOUT + 4);
        bus.sensor_entrance = 1'b0;
        cyc(3);

        // Fill the lot, FULL display, departure releases it
        for (int i = 0; i < 30 && m_occ < CAP; i++) admit_car(1'b0);
        bus.sensor_entrance = 1'b1;
        cyc(6);
        bus.sensor_depart = 1'b1;
        cyc();
        bus.sensor_depart = 1'b0;
        cyc(3);
        enter_code(PW);
        cyc(2);
        bus.sensor_entrance = 1'b0;
        bus.sensor_exit     = 1'b1;
        bus.sensor_depart   = 1'b1;
        cyc();
        bus.sensor_exit     = 1'b0;
        bus.sensor_depart   = 1'b0;
        cyc(3);

        // WAIT_PASS timeout with the car still present
        bus.sensor_entrance = 1'b1;
        cyc(PASS_TIMEOUT + 6);
        bus.sensor_entrance = 1'b0;
        cyc(3);

        // Randomized lane traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 15) == 0) bus.sensor_entrance = ~bus.sensor_entrance;
            bus.sensor_exit   = ($urandom_range(0, 9) == 0);
            bus.sensor_depart = ($urandom_range(0, 11) == 0);
            bus.pass_valid    = ($urandom_range(0, 5) == 0);
            bus.pass_code     = ($urandom_range(0, 2) == 0) ? PW : 4'($urandom);
            cyc();
        end
        bus.sensor_entrance = 1'b0;
        bus.sensor_exit     = 1'b0;
        bus.sensor_depart   = 1'b0;
        bus.pass_valid      = 1'b0;
        cyc(4);

        // Asynchronous reset in the middle of GRANTED
        admit_car(1'b0);
        bus.sensor_entrance = 1'b1;
        cyc(2);
        enter_code(PW);
        cyc(3);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_green",     32'(bus.GREEN_LED), 32'd0);
        chk("rst_red",       32'(bus.RED_LED),   32'd0);
        chk("rst_gate_open", 32'(bus.gate_open), 32'd0);
        chk("rst_lot_full",  32'(bus.lot_full),  32'd0);
        chk("rst_occupancy", 32'(bus.occupancy), 32'd0);
        chk("rst_hex",       32'({bus.HEX_1, bus.HEX_2}), 32'h3FFF);
        bus.sensor_entrance = 1'b0;
        cyc(2);
        #2 reset_n = 1'b1;
        cyc(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
